// File: rtl/core_bus_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : core_bus_bridge
//  Purpose  : Arbitrates the core's instruction port (ibus) and data port
//             (dbus) onto a single cache/memory bus (cbus). Only one
//             transaction is in flight at a time. Request fields are latched
//             at grant, and the completion is returned as a one-cycle
//             registered data_ok pulse to the port that owns the transaction.
//  Revision : 1.0 - initial release
//
//  Ports
//    clk, reset          : clock, synchronous active-high reset
//    ireq_*              : fetch request (valid, addr)
//    iresp_*             : fetch completion pulse and 32-bit instruction
//    dreq_*              : data request (valid, addr, size, strobe, data)
//    dresp_*             : data completion pulse and raw 64-bit load word
//    creq_*              : cbus request, held stable while a transaction runs
//    cresp_*             : cbus beat handshake (ready, last, data)
//
//  Build option
//    BRIDGE_ROUND_ROBIN_EN : when defined, a tie (both ports valid in IDLE)
//                            goes to the port that was not served last.
//                            When undefined, the data port always wins a tie.
// ============================================================================
module core_bus_bridge #(
  parameter int         ADDR_W      = 64,
  parameter int         DATA_W      = 64,
  parameter logic [2:0] IFETCH_SIZE = 3'b010
) (
  input  logic              clk,
  input  logic              reset,
  // instruction port
  input  logic              ireq_valid,
  input  logic [ADDR_W-1:0] ireq_addr,
  output logic              iresp_data_ok,
  output logic [31:0]       iresp_data,
  // data port
  input  logic              dreq_valid,
  input  logic [ADDR_W-1:0] dreq_addr,
  input  logic [2:0]        dreq_size,
  input  logic [7:0]        dreq_strobe,
  input  logic [DATA_W-1:0] dreq_data,
  output logic              dresp_data_ok,
  output logic [DATA_W-1:0] dresp_data,
  // cache/memory bus
  output logic              creq_valid,
  output logic              creq_is_write,
  output logic [2:0]        creq_size,
  output logic [ADDR_W-1:0] creq_addr,
  output logic [7:0]        creq_strobe,
  output logic [DATA_W-1:0] creq_data,
  input  logic              cresp_ready,
  input  logic              cresp_last,
  input  logic [DATA_W-1:0] cresp_data
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  state_t              state_q;
  owner_t              owner_q;
  logic                creq_valid_q;
  logic                is_write_q;
  logic [2:0]          size_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [7:0]          strobe_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   word_q;
  logic                iresp_ok_q;
  logic                dresp_ok_q;

  logic                tie_pick_d;
  logic                grant_dport;

`ifdef BRIDGE_ROUND_ROBIN_EN
  owner_t              last_owner_q;
  // On a tie, serve whichever port was not served by the previous grant.
  assign tie_pick_d = (last_owner_q == OWN_I);
`else
  assign tie_pick_d = 1'b1;
`endif

  // The data port is granted when it is the only requester, or when both
  // request and the tie-break favours it.
  assign grant_dport = dreq_valid && (!ireq_valid || tie_pick_d);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_I;
      creq_valid_q <= 1'b0;
      is_write_q   <= 1'b0;
      size_q       <= 3'd0;
      addr_q       <= '0;
      strobe_q     <= 8'd0;
      wdata_q      <= '0;
      word_q       <= '0;
      iresp_ok_q   <= 1'b0;
      dresp_ok_q   <= 1'b0;
`ifdef BRIDGE_ROUND_ROBIN_EN
      last_owner_q <= OWN_D;
`endif
    end else begin
      // data_ok is a single-cycle pulse; only the BUSY->RESP step raises it.
      iresp_ok_q <= 1'b0;
      dresp_ok_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (ireq_valid || dreq_valid) begin
            state_q      <= ST_BUSY;
            creq_valid_q <= 1'b1;
            if (grant_dport) begin
              owner_q    <= OWN_D;
              addr_q     <= dreq_addr;
              size_q     <= dreq_size;
              strobe_q   <= dreq_strobe;
              wdata_q    <= dreq_data;
              is_write_q <= (dreq_strobe != 8'd0);
            end else begin
              owner_q    <= OWN_I;
              addr_q     <= ireq_addr;
              size_q     <= IFETCH_SIZE;
              strobe_q   <= 8'd0;
              wdata_q    <= '0;
              is_write_q <= 1'b0;
            end
`ifdef BRIDGE_ROUND_ROBIN_EN
            last_owner_q <= grant_dport ? OWN_D : OWN_I;
`endif
          end
        end

        ST_BUSY: begin
          // Every accepted beat overwrites the word, so the last beat wins.
          if (cresp_ready) begin
            word_q <= cresp_data;
            if (cresp_last) begin
              state_q      <= ST_RESP;
              creq_valid_q <= 1'b0;
              iresp_ok_q   <= (owner_q == OWN_I);
              dresp_ok_q   <= (owner_q == OWN_D);
            end
          end
        end

        // One-cycle gap so the core can advance before a new grant is made.
        ST_RESP: begin
          state_q <= ST_IDLE;
        end

        default: begin
          state_q      <= ST_IDLE;
          creq_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign creq_valid    = creq_valid_q;
  assign creq_is_write = is_write_q;
  assign creq_size     = size_q;
  assign creq_addr     = addr_q;
  assign creq_strobe   = strobe_q;
  assign creq_data     = wdata_q;

  assign iresp_data_ok = iresp_ok_q;
  assign dresp_data_ok = dresp_ok_q;
  // Fetch address bit 2 selects which 32-bit half of the word is the
  // instruction; both sources are registers, so this adds no cbus path.
  assign iresp_data    = addr_q[2] ? word_q[63:32] : word_q[31:0];
  assign dresp_data    = word_q;

endmodule
`default_nettype wire

// File: tb/tb_core_bus_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_core_bus_bridge
//  Purpose  : Self-checking bench for core_bus_bridge. Directed table of
//             single-port transactions, hand-written multi-cycle sequences
//             (tie arbitration, flush, reset mid-transaction) and randomized
//             transactions checked against a transaction-level model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_core_bus_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        dreq_valid;
  logic [63:0] dreq_addr;
  logic [2:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_data;
  logic        dresp_data_ok;
  logic [63:0] dresp_data;
  logic        creq_valid;
  logic        creq_is_write;
  logic [2:0]  creq_size;
  logic [63:0] creq_addr;
  logic [7:0]  creq_strobe;
  logic [63:0] creq_data;
  logic        cresp_ready;
  logic        cresp_last;
  logic [63:0] cresp_data;

  core_bus_bridge dut (
    .clk           (clk),
    .reset         (reset),
    .ireq_valid    (ireq_valid),
    .ireq_addr     (ireq_addr),
    .iresp_data_ok (iresp_data_ok),
    .iresp_data    (iresp_data),
    .dreq_valid    (dreq_valid),
    .dreq_addr     (dreq_addr),
    .dreq_size     (dreq_size),
    .dreq_strobe   (dreq_strobe),
    .dreq_data     (dreq_data),
    .dresp_data_ok (dresp_data_ok),
    .dresp_data    (dresp_data),
    .creq_valid    (creq_valid),
    .creq_is_write (creq_is_write),
    .creq_size     (creq_size),
    .creq_addr     (creq_addr),
    .creq_strobe   (creq_strobe),
    .creq_data     (creq_data),
    .cresp_ready   (cresp_ready),
    .cresp_last    (cresp_last),
    .cresp_data    (cresp_data)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit m_last_d;   // model: port served by the most recent grant (1 = D)

  typedef struct {
    bit          d;
    logic [63:0] addr;
    logic [2:0]  size;
    bit          wr;
    logic [7:0]  stb;
    logic [63:0] wd;
  } fields_t;

  typedef struct {
    bit          iv;
    logic [63:0] ia;
    bit          dv;
    logic [63:0] da;
    logic [2:0]  dsz;
    logic [7:0]  dstb;
    logic [63:0] dd;
    int          gap;
    int          nb;
    logic [63:0] rd;
    bit          e_d;
    logic [63:0] e_addr;
    logic [2:0]  e_size;
    bit          e_wr;
    logic [7:0]  e_stb;
    logic [63:0] e_wd;
    logic [63:0] e_rsp;
    bit          e_chk;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Arbitration rule at the transaction level.
  function automatic bit model_pick_d(input bit iv, input bit dv);
    if (iv && dv) begin
`ifdef BRIDGE_ROUND_ROBIN_EN
      return !m_last_d;
`else
      return 1'b1;
`endif
    end
    return dv;
  endfunction

  function automatic fields_t model_fields(input bit d, input logic [63:0] ia,
                                           input logic [63:0] da, input logic [2:0] dsz,
                                           input logic [7:0] dstb, input logic [63:0] dd);
    fields_t f;
    f.d = d;
    if (d) begin
      f.addr = da; f.size = dsz; f.wr = (dstb != 8'd0); f.stb = dstb; f.wd = dd;
    end else begin
      f.addr = ia; f.size = 3'b010; f.wr = 1'b0; f.stb = 8'd0; f.wd = 64'd0;
    end
    return f;
  endfunction

  function automatic logic [63:0] model_rsp(input fields_t f, input logic [63:0] rd);
    if (f.d) return rd;
    return f.addr[2] ? {32'd0, rd[63:32]} : {32'd0, rd[31:0]};
  endfunction

  task automatic check_fields(input string tag, input fields_t f);
    chk({tag, ".creq_valid"}, creq_valid, 1);
    chk({tag, ".creq_addr"}, creq_addr, f.addr);
    chk({tag, ".creq_size"}, creq_size, f.size);
    chk({tag, ".creq_is_write"}, creq_is_write, f.wr);
    chk({tag, ".creq_strobe"}, creq_strobe, f.stb);
    chk({tag, ".creq_data"}, creq_data, f.wd);
  endtask

  // Called at a negedge with the bridge IDLE and the requests already driven.
  // Grant must appear on the very next negedge.
  task automatic run_one(input fields_t f, input int gap, input int nb,
                         input logic [63:0] rd, input logic [63:0] e_rsp, input bit chk_rsp,
                         input bit drop_i, input bit drop_d, input bit drop_mid_i);
    int waited = 0;
    while (creq_valid !== 1'b1 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    chk("grant_latency", waited, 1);
    if (creq_valid !== 1'b1) return;
    m_last_d = f.d;
    check_fields("grant", f);
    if (drop_mid_i) ireq_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      cresp_ready = 1'b0;
      cresp_last  = 1'b1;
      @(negedge clk);
      check_fields("wait", f);
      chk("no_ok_while_busy", {iresp_data_ok, dresp_data_ok}, 0);
    end
    for (int k = 0; k < nb; k++) begin
      cresp_ready = 1'b1;
      cresp_last  = (k == nb - 1);
      cresp_data  = (k == nb - 1) ? rd : (rd ^ (64'hA5A5_5A5A_0F0F_F0F0 + 64'(k)));
      @(negedge clk);
      if (k != nb - 1) begin
        check_fields("beat", f);
        chk("no_ok_midbeat", {iresp_data_ok, dresp_data_ok}, 0);
      end
    end
    cresp_ready = 1'b0;
    cresp_last  = 1'b0;
    cresp_data  = 64'hFFFF_0000_FFFF_0000;
    chk("iresp_data_ok", iresp_data_ok, !f.d);
    chk("dresp_data_ok", dresp_data_ok, f.d);
    chk("resp_creq_valid", creq_valid, 0);
    if (chk_rsp) begin
      if (f.d) chk("dresp_data", dresp_data, e_rsp);
      else     chk("iresp_data", iresp_data, e_rsp);
    end
    if (drop_i) ireq_valid = 1'b0;
    if (drop_d) dreq_valid = 1'b0;
    @(negedge clk);
    chk("ok_pulse_end", {iresp_data_ok, dresp_data_ok}, 0);
    chk("no_grant_after_resp", creq_valid, 0);
  endtask

  vec_t    tbl[7];
  fields_t f, f2;
  bit      iv, dv, pd;
  logic [63:0] ia, da, dd, rd, rd2;
  logic [2:0]  dsz;
  logic [7:0]  dstb;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{1, 64'h8000_0004, 0, 64'h0, 3'd3, 8'hFF, 64'hCAFE, 2, 1,
               64'hDEADBEEF_00000013, 0, 64'h8000_0004, 3'd2, 0, 8'h00, 64'h0, 64'hDEADBEEF, 1};
    tbl[1] = '{1, 64'h8000_0000, 0, 64'h0, 3'd0, 8'h00, 64'h0, 0, 1,
               64'h00000013_12345678, 0, 64'h8000_0000, 3'd2, 0, 8'h00, 64'h0, 64'h12345678, 1};
    tbl[2] = '{0, 64'h0, 1, 64'h8000_1000, 3'd3, 8'h00, 64'h55, 1, 1,
               64'h01234567_89ABCDEF, 1, 64'h8000_1000, 3'd3, 0, 8'h00, 64'h55, 64'h01234567_89ABCDEF, 1};
    tbl[3] = '{0, 64'h0, 1, 64'h8000_2000, 3'd2, 8'h0F, 64'h11223344, 4, 1,
               64'h0, 1, 64'h8000_2000, 3'd2, 1, 8'h0F, 64'h11223344, 64'h0, 0};
    tbl[4] = '{0, 64'h0, 1, 64'h8000_3008, 3'd3, 8'h00, 64'h0, 0, 2,
               64'hBBBB_BBBB_BBBB_BBBB, 1, 64'h8000_3008, 3'd3, 0, 8'h00, 64'h0, 64'hBBBB_BBBB_BBBB_BBBB, 1};
    tbl[5] = '{1, 64'h8000_000C, 0, 64'h0, 3'd1, 8'h3C, 64'h77, 1, 3,
               64'h00000073_FFFFFFFF, 0, 64'h8000_000C, 3'd2, 0, 8'h00, 64'h0, 64'h00000073, 1};
    tbl[6] = '{0, 64'h0, 1, 64'h9000_0000, 3'd3, 8'hFF, 64'h01020304_05060708, 0, 2,
               64'h0, 1, 64'h9000_0000, 3'd3, 1, 8'hFF, 64'h01020304_05060708, 64'h0, 0};

    reset = 1'b1;
    ireq_valid = 0; ireq_addr = 0;
    dreq_valid = 0; dreq_addr = 0; dreq_size = 0; dreq_strobe = 0; dreq_data = 0;
    cresp_ready = 0; cresp_last = 0; cresp_data = 64'h1234;
    repeat (3) @(negedge clk);
    chk("rst.creq_valid", creq_valid, 0);
    chk("rst.creq_fields", {creq_is_write, creq_size, creq_strobe}, 0);
    chk("rst.creq_addr", creq_addr, 0);
    chk("rst.creq_data", creq_data, 0);
    chk("rst.data_ok", {iresp_data_ok, dresp_data_ok}, 0);
    chk("rst.iresp_data", iresp_data, 0);
    chk("rst.dresp_data", dresp_data, 0);
    reset = 1'b0;
    m_last_d = 1'b1;
    @(negedge clk);
    chk("idle_no_request", creq_valid, 0);

    // Directed single-port transactions.
    for (int i = 0; i < 7; i++) begin
      ireq_valid = tbl[i].iv; ireq_addr = tbl[i].ia;
      dreq_valid = tbl[i].dv; dreq_addr = tbl[i].da; dreq_size = tbl[i].dsz;
      dreq_strobe = tbl[i].dstb; dreq_data = tbl[i].dd;
      f = '{tbl[i].e_d, tbl[i].e_addr, tbl[i].e_size, tbl[i].e_wr, tbl[i].e_stb, tbl[i].e_wd};
      run_one(f, tbl[i].gap, tbl[i].nb, tbl[i].rd, tbl[i].e_rsp, tbl[i].e_chk, 1, 1, 0);
    end

    // Tie: both ports request together; loser is served right after.
    ireq_valid = 1; ireq_addr = 64'h8000_0040;
    dreq_valid = 1; dreq_addr = 64'h8000_1000; dreq_size = 3'd3; dreq_strobe = 0; dreq_data = 64'h9;
    pd = model_pick_d(1, 1);
    f  = model_fields(pd, ireq_addr, dreq_addr, dreq_size, dreq_strobe, dreq_data);
    f2 = model_fields(!pd, ireq_addr, dreq_addr, dreq_size, dreq_strobe, dreq_data);
    rd = 64'h11111111_22222222;
    run_one(f, 1, 1, rd, model_rsp(f, rd), 1, !pd, pd, 0);
    rd = 64'h33333333_44444444;
    run_one(f2, 0, 1, rd, model_rsp(f2, rd), 1, 1, 1, 0);

    // Flush: fetch valid drops while BUSY; completion still pulses once.
    ireq_valid = 1; ireq_addr = 64'h8000_0084;
    f  = model_fields(0, ireq_addr, 0, 0, 0, 0);
    rd = 64'hCAFEF00D_00000000;
    run_one(f, 2, 1, rd, 64'hCAFEF00D, 1, 1, 1, 1);
    @(negedge clk);
    chk("flush_idle", {creq_valid, iresp_data_ok, dresp_data_ok}, 0);

    // Reset in the second BUSY cycle, with a completing beat on the bus.
    ireq_valid = 1; ireq_addr = 64'h8000_0100;
    @(negedge clk);
    chk("rstbusy.c1_valid", creq_valid, 1);
    @(negedge clk);
    chk("rstbusy.c2_valid", creq_valid, 1);
    reset = 1; cresp_ready = 1; cresp_last = 1; cresp_data = 64'hBAD0BAD0_BAD0BAD0;
    @(negedge clk);
    reset = 0; cresp_ready = 0; cresp_last = 0;
    m_last_d = 1'b1;
    chk("rstbusy.creq_valid", creq_valid, 0);
    chk("rstbusy.no_ok", {iresp_data_ok, dresp_data_ok}, 0);
    f  = model_fields(0, ireq_addr, 0, 0, 0, 0);
    rd = 64'h0000AAAA_0000BBBB;
    run_one(f, 0, 1, rd, 64'h0000BBBB, 1, 1, 1, 0);

    // Randomized transactions against the transaction-level model.
    for (int n = 0; n < 40; n++) begin
      iv = $urandom_range(0, 1);
      dv = $urandom_range(0, 1);
      if (!iv && !dv) iv = 1;
      ia   = {$urandom, $urandom};
      da   = {$urandom, $urandom};
      dsz  = 3'($urandom_range(0, 3));
      dstb = ($urandom_range(0, 1) != 0) ? 8'($urandom) : 8'd0;
      dd   = {$urandom, $urandom};
      rd   = {$urandom, $urandom};
      rd2  = {$urandom, $urandom};
      ireq_valid = iv; ireq_addr = ia;
      dreq_valid = dv; dreq_addr = da; dreq_size = dsz; dreq_strobe = dstb; dreq_data = dd;
      pd = model_pick_d(iv, dv);
      f  = model_fields(pd, ia, da, dsz, dstb, dd);
      if (iv && dv) begin
        run_one(f, $urandom_range(0, 3), $urandom_range(1, 3), rd, model_rsp(f, rd),
                !f.wr, !pd, pd, 0);
        f2 = model_fields(!pd, ia, da, dsz, dstb, dd);
        run_one(f2, $urandom_range(0, 3), $urandom_range(1, 3), rd2, model_rsp(f2, rd2),
                !f2.wr, 1, 1, 0);
      end else begin
        run_one(f, $urandom_range(0, 3), $urandom_range(1, 3), rd, model_rsp(f, rd),
                !f.wr, 1, 1, 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
